// File: rtl/fft_reorder_buffer.sv
// Ping-pong frame buffer on the streaming FFT output: reorders bit-reversed bins into
// natural order (or passes them through) with valid/ready on both sides.
module fft_reorder_buffer #(
    parameter int N_POINTS  = 32,
    parameter int DATA_W    = 16,
    parameter int BITREV_EN = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_W-1:0]    in_real,
    input  logic signed [DATA_W-1:0]    in_imag,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_W-1:0]    out_real,
    output logic signed [DATA_W-1:0]    out_imag,
    output logic [$clog2(N_POINTS)-1:0] out_index,
    output logic                        out_last,
    output logic                        frame_done,
    output logic                        frame_err
);

    localparam int AW = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST_CNT = AW'(N_POINTS - 1);

    logic [2*DATA_W-1:0] mem [2][N_POINTS];

    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] wr_rev;
    logic [AW-1:0] wr_addr;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wr_fire;
    logic          rd_fire;
    logic          wr_end;
    logic          rd_end;

    assign wr_rev = {<<{wr_cnt}};

    always_comb begin
        in_ready  = !full[wr_bank];
        out_valid = full[rd_bank];
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid && out_ready;
        wr_end    = (wr_cnt == LAST_CNT);
        rd_end    = (rd_cnt == LAST_CNT);
        wr_addr   = (BITREV_EN != 0) ? wr_rev : wr_cnt;
        out_index = rd_cnt;
        out_last  = out_valid && rd_end;
        {out_real, out_imag} = mem[rd_bank][rd_cnt];
    end

    // Write-close and read-drain always target different banks, so both edits apply.
    always_comb begin
        full_nxt = full;
        if (wr_fire && wr_end) full_nxt[wr_bank] = 1'b1;
        if (rd_fire && rd_end) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            full       <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            full       <= full_nxt;
            frame_done <= rd_fire && rd_end;
            if (wr_fire) begin
                wr_cnt <= wr_end ? '0 : wr_cnt + 1'b1;
                if (wr_end) wr_bank <= !wr_bank;
                if (in_last != wr_end) frame_err <= 1'b1;
            end
            if (rd_fire) begin
                rd_cnt <= rd_end ? '0 : rd_cnt + 1'b1;
                if (rd_end) rd_bank <= !rd_bank;
            end
        end
    end

    // Bank storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_bank][wr_addr] <= {in_real, in_imag};
    end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Bench for fft_reorder_buffer: bit-reversing instance checked through a scoreboard,
// pass-through instance checked against a vector table.
module tb_fft_reorder_buffer;
    localparam int N   = 32;
    localparam int W   = 16;
    localparam int TMO = 500;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [4:0]   idx;
        logic         last;
    } exp_t;

    typedef struct {
        logic [W-1:0] in_re;
        logic [W-1:0] in_im;
        logic         in_last;
        logic [W-1:0] ex_re;
        logic [W-1:0] ex_im;
        logic [4:0]   ex_idx;
        logic         ex_last;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid, in_ready, in_last, out_valid, out_ready, out_last, frame_done, frame_err;
    logic [W-1:0] in_real, in_imag, out_real, out_imag;
    logic [4:0]   out_index;

    logic         d2_in_valid, d2_in_ready, d2_in_last, d2_out_valid, d2_out_ready, d2_out_last;
    logic         d2_frame_done, d2_frame_err;
    logic [W-1:0] d2_in_real, d2_in_imag, d2_out_real, d2_out_imag;
    logic [4:0]   d2_out_index;

    fft_reorder_buffer #(.N_POINTS(N), .DATA_W(W), .BITREV_EN(1)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
        .out_last(out_last), .frame_done(frame_done), .frame_err(frame_err)
    );

    fft_reorder_buffer #(.N_POINTS(N), .DATA_W(W), .BITREV_EN(0)) u_dut_nat (
        .clk(clk), .reset(reset),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_real(d2_in_real), .in_imag(d2_in_imag),
        .in_last(d2_in_last), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_real(d2_out_real), .out_imag(d2_out_imag), .out_index(d2_out_index),
        .out_last(d2_out_last), .frame_done(d2_frame_done), .frame_err(d2_frame_err)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   stalls = 0;
    int   n_acc = 0;
    int   n_pop = 0;
    logic mon_en = 1'b0;
    logic done_pend = 1'b0;
    exp_t mon_e;
    exp_t sbq[$];
    vec_t tbl[N];

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
        logic ok;
        int   t;
        ok = 1'b0;
        t  = 0;
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        in_last  = last;
        while (!ok && t < TMO) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) check("accept_timeout", 32'(0), 32'(1));
        else n_acc++;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] base, input logic [W-1:0] im_mask, input int last_pos);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) begin
            v = base + W'(i);
            send(v, ~v & im_mask, (i == last_pos));
        end
        for (int k = 0; k < N; k++) begin
            v = base + W'(bitrev5(5'(k)));
            sbq.push_back('{re: v, im: ~v & im_mask, idx: 5'(k), last: (k == N - 1)});
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(sbq.size()), 32'(0));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted output bin pops one expectation.
    always @(negedge clk) begin
        if (!mon_en) begin
            done_pend = 1'b0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(done_pend));
            done_pend = 1'b0;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", 32'(out_index), 32'hffff_ffff);
                end else begin
                    mon_e = sbq.pop_front();
                    n_pop++;
                    check("out_real",  32'(out_real),  32'(mon_e.re));
                    check("out_imag",  32'(out_imag),  32'(mon_e.im));
                    check("out_index", 32'(out_index), 32'(mon_e.idx));
                    check("out_last",  32'(out_last),  32'(mon_e.last));
                    done_pend = mon_e.last;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int a0, s0, p0;

        for (int i = 0; i < N; i++) begin
            tbl[i].in_re   = (i < 16) ? 16'h007f : 16'hff81;
            tbl[i].in_im   = (i < 16) ? 16'hff81 : 16'h007f;
            tbl[i].in_last = (i == N - 1);
            tbl[i].ex_re   = (i < 16) ? 16'h007f : 16'hff81;
            tbl[i].ex_im   = (i < 16) ? 16'hff81 : 16'h007f;
            tbl[i].ex_idx  = 5'(i);
            tbl[i].ex_last = (i == N - 1);
        end

        reset = 1'b0;
        in_valid = 1'b0; in_real = '0; in_imag = '0; in_last = 1'b0; out_ready = 1'b0;
        d2_in_valid = 1'b0; d2_in_real = '0; d2_in_imag = '0; d2_in_last = 1'b0; d2_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   32'(in_ready),      32'(1));
        check("rst_out_valid",  32'(out_valid),     32'(0));
        check("rst_frame_done", 32'(frame_done),    32'(0));
        check("rst_frame_err",  32'(frame_err),     32'(0));
        check("rst_out_index",  32'(out_index),     32'(0));
        check("rst2_in_ready",  32'(d2_in_ready),   32'(1));
        check("rst2_out_valid", 32'(d2_out_valid),  32'(0));
        reset  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through instance, table driven.
        for (int i = 0; i < N; i++) begin
            d2_in_valid = 1'b1;
            d2_in_real  = tbl[i].in_re;
            d2_in_imag  = tbl[i].in_im;
            d2_in_last  = tbl[i].in_last;
            check("t2_in_ready", 32'(d2_in_ready), 32'(1));
            @(posedge clk);
            #1;
        end
        d2_in_valid = 1'b0;
        d2_in_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("t2_out_valid",  32'(d2_out_valid),  32'(1));
            check("t2_out_real",   32'(d2_out_real),   32'(tbl[i].ex_re));
            check("t2_out_imag",   32'(d2_out_imag),   32'(tbl[i].ex_im));
            check("t2_out_index",  32'(d2_out_index),  32'(tbl[i].ex_idx));
            check("t2_out_last",   32'(d2_out_last),   32'(tbl[i].ex_last));
            check("t2_frame_done", 32'(d2_frame_done), 32'(0));
            @(posedge clk);
            #1;
        end
        check("t2_done_pulse", 32'(d2_frame_done), 32'(1));
        check("t2_empty",      32'(d2_out_valid),  32'(0));
        @(posedge clk);
        #1;
        check("t2_done_once",  32'(d2_frame_done), 32'(0));
        check("t2_frame_err",  32'(d2_frame_err),  32'(0));

        // Ordering: in_real = i, in_imag = 0.
        out_ready = 1'b1;
        send_frame(16'h0000, 16'h0000, N - 1);
        wait_drain("t1_drain");

        // Backpressure over three frames.
        out_ready = 1'b0;
        a0 = n_acc;
        p0 = n_pop;
        send_frame(16'h0100, 16'hffff, N - 1);
        send_frame(16'h0140, 16'hffff, N - 1);
        check("t3_accepted", 32'(n_acc - a0), 32'(64));
        in_valid = 1'b1;
        in_real  = 16'h0180;
        in_imag  = ~16'h0180;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t3_in_ready",  32'(in_ready),  32'(0));
            check("t3_out_valid", 32'(out_valid), 32'(1));
            check("t3_hold_idx",  32'(out_index), 32'(0));
            check("t3_hold_real", 32'(out_real),  32'(sbq[0].re));
        end
        @(posedge clk);
        #1;
        s0 = stalls;
        fork
            send_frame(16'h0180, 16'hffff, N - 1);
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("t3_stalled", 32'(stalls > s0), 32'(1));
        wait_drain("t3_drain");
        check("t3_popped", 32'(n_pop - p0), 32'(96));

        // Continuous streaming, four back-to-back frames.
        s0 = stalls;
        fork
            begin
                send_frame(16'h1000, 16'hffff, N - 1);
                check("t4_first_valid", 32'(out_valid), 32'(1));
                check("t4_first_index", 32'(out_index), 32'(0));
                for (int f = 1; f < 4; f++) send_frame(16'h1000 + W'(f * 64), 16'hffff, N - 1);
            end
            begin
                int  nv, nb;
                logic started;
                nv = 0;
                nb = 0;
                started = 1'b0;
                for (int c = 0; c < 400 && nv < 4 * N; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        nv++;
                        started = 1'b1;
                    end else if (started) begin
                        nb++;
                    end
                end
                check("t4_valid_beats", 32'(nv), 32'(4 * N));
                check("t4_bubbles",     32'(nb), 32'(0));
            end
        join
        check("t4_no_stall", 32'(stalls - s0), 32'(0));
        wait_drain("t4_drain");

        // Misaligned in_last.
        check("t5_err_before", 32'(frame_err), 32'(0));
        send_frame(16'h2000, 16'h00ff, 20);
        check("t5_err_set", 32'(frame_err), 32'(1));
        wait_drain("t5_drain");
        check("t5_err_sticky", 32'(frame_err), 32'(1));

        // Reset while frame 1 drains and frame 2 is part-written.
        send_frame(16'h3000, 16'hffff, N - 1);
        for (int i = 0; i < 10; i++) send(16'h3100 + W'(i), 16'h0000, 1'b0);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("t6_out_valid",  32'(out_valid),  32'(0));
        check("t6_in_ready",   32'(in_ready),   32'(1));
        check("t6_frame_err",  32'(frame_err),  32'(0));
        check("t6_out_index",  32'(out_index),  32'(0));
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        send_frame(16'h4000, 16'hffff, N - 1);
        wait_drain("t6_drain");
        check("t6_idle", 32'(out_valid), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
